// File: rtl/rect_fill_engine.sv
// Rectangle fill / screen clear engine: walks a clamped rectangle (or the whole screen)
// in raster order and emits one framebuffer write per cycle.
module rect_fill_engine #(
  parameter int unsigned N        = 11,
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] x0,
  input  logic [N-1:0] y0,
  input  logic [N-1:0] x1,
  input  logic [N-1:0] y1,
  input  logic         wr,
  input  logic         clearScreen,
  output logic         ready,
  output logic [N-1:0] pix_x,
  output logic [N-1:0] pix_y,
  output logic         pix_color,
  output logic         pix_we,
  output logic         done
);

  typedef enum logic [1:0] {StIdle, StClear, StFill} state_e;

  // One extra bit so a screen size of 2**N still compares correctly.
  localparam logic [N:0]   W_EXT = (N+1)'(SCREEN_W);
  localparam logic [N:0]   H_EXT = (N+1)'(SCREEN_H);
  localparam logic [N-1:0] X_MAX = N'(SCREEN_W - 1);
  localparam logic [N-1:0] Y_MAX = N'(SCREEN_H - 1);

  state_e       r_state;
  logic         r_clr_pend;
  logic [N-1:0] r_xa;
  logic [N-1:0] r_xb;
  logic [N-1:0] r_yb;
  logic [N-1:0] r_pix_x;
  logic [N-1:0] r_pix_y;
  logic         r_pix_color;
  logic         r_pix_we;
  logic         r_done;

  logic [N-1:0] w_xa;
  logic [N-1:0] w_xb;
  logic [N-1:0] w_ya;
  logic [N-1:0] w_yb;
  logic [N-1:0] w_xb_clamp;
  logic [N-1:0] w_yb_clamp;
  logic         w_empty;
  logic         w_last_x;
  logic         w_last_y;

  assign w_xa       = (x0 < x1) ? x0 : x1;
  assign w_xb       = (x0 < x1) ? x1 : x0;
  assign w_ya       = (y0 < y1) ? y0 : y1;
  assign w_yb       = (y0 < y1) ? y1 : y0;
  assign w_xb_clamp = ({1'b0, w_xb} >= W_EXT) ? X_MAX : w_xb;
  assign w_yb_clamp = ({1'b0, w_yb} >= H_EXT) ? Y_MAX : w_yb;
  assign w_empty    = ({1'b0, w_xa} >= W_EXT) || ({1'b0, w_ya} >= H_EXT);

  // The pixel address registers double as the scan counters.
  assign w_last_x = (r_pix_x == r_xb);
  assign w_last_y = (r_pix_y == r_yb);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= StIdle;
      r_clr_pend  <= 1'b0;
      r_xa        <= '0;
      r_xb        <= '0;
      r_yb        <= '0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_pix_color <= 1'b0;
      r_pix_we    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (clearScreen || r_clr_pend) begin
            r_clr_pend  <= 1'b0;
            r_state     <= StClear;
            r_xa        <= '0;
            r_xb        <= X_MAX;
            r_yb        <= Y_MAX;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
            r_pix_color <= 1'b0;
            r_pix_we    <= 1'b1;
          end else if (wr) begin
            if (w_empty) begin
              r_done <= 1'b1;
            end else begin
              r_state     <= StFill;
              r_xa        <= w_xa;
              r_xb        <= w_xb_clamp;
              r_yb        <= w_yb_clamp;
              r_pix_x     <= w_xa;
              r_pix_y     <= w_ya;
              r_pix_color <= 1'b1;
              r_pix_we    <= 1'b1;
            end
          end
        end
        StClear, StFill: begin
          if (clearScreen) begin
            r_clr_pend <= 1'b1;
          end
          if (w_last_x && w_last_y) begin
            r_state  <= StIdle;
            r_pix_we <= 1'b0;
            r_done   <= 1'b1;
          end else if (w_last_x) begin
            r_pix_x <= r_xa;
            r_pix_y <= r_pix_y + 1'b1;
          end else begin
            r_pix_x <= r_pix_x + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign ready     = (r_state == StIdle) && !r_clr_pend;
  assign pix_x     = r_pix_x;
  assign pix_y     = r_pix_y;
  assign pix_color = r_pix_color;
  assign pix_we    = r_pix_we;
  assign done      = r_done;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Bench for rect_fill_engine: directed scenarios plus random traffic, checked cycle by cycle
// against a queue-of-pixels reference model.
module tb_rect_fill_engine;

  localparam int N = 11;
  localparam int W = 8;
  localparam int H = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         wr;
  logic         clearScreen;
  logic [N-1:0] x0;
  logic [N-1:0] y0;
  logic [N-1:0] x1;
  logic [N-1:0] y1;
  logic         ready;
  logic [N-1:0] pix_x;
  logic [N-1:0] pix_y;
  logic         pix_color;
  logic         pix_we;
  logic         done;

  rect_fill_engine #(
    .N       (N),
    .SCREEN_W(W),
    .SCREEN_H(H)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .x0         (x0),
    .y0         (y0),
    .x1         (x1),
    .y1         (y1),
    .wr         (wr),
    .clearScreen(clearScreen),
    .ready      (ready),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_color  (pix_color),
    .pix_we     (pix_we),
    .done       (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int x;
    int y;
    bit c;
  } pix_t;

  // Model: pixels still to be written, plus what the outputs should show this cycle.
  pix_t m_q[$];
  bit   m_we, m_done, m_c, m_pend;
  int   m_x, m_y;

  int n_total  = 0;
  int n_bad    = 0;
  int cyc_n    = 0;
  int n_writes = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc_n, got, exp);
    end
  endtask

  task automatic model_pop();
    pix_t p;
    p    = m_q.pop_front();
    m_x  = p.x;
    m_y  = p.y;
    m_c  = p.c;
    m_we = 1'b1;
  endtask

  task automatic model_load_rect(input int a, input int b, input int c, input int d);
    int xa, xb, ya, yb;
    xa = (a < c) ? a : c;
    xb = (a < c) ? c : a;
    ya = (b < d) ? b : d;
    yb = (b < d) ? d : b;
    if (xb > W - 1) xb = W - 1;
    if (yb > H - 1) yb = H - 1;
    if (xa >= W || ya >= H) return;
    for (int y = ya; y <= yb; y++)
      for (int x = xa; x <= xb; x++) m_q.push_back('{x, y, 1'b1});
  endtask

  task automatic model_step(input bit r, input bit w, input bit c,
                            input int a, input int b, input int cc, input int d);
    if (r) begin
      m_q.delete();
      m_we = 0; m_done = 0; m_pend = 0;
      m_x = 0; m_y = 0; m_c = 0;
    end else if (!m_we) begin
      m_done = 0;
      if (c || m_pend) begin
        m_pend = 0;
        for (int y = 0; y < H; y++)
          for (int x = 0; x < W; x++) m_q.push_back('{x, y, 1'b0});
        model_pop();
      end else if (w) begin
        model_load_rect(a, b, cc, d);
        if (m_q.size() == 0) m_done = 1;
        else model_pop();
      end
    end else begin
      if (c) m_pend = 1;
      if (m_q.size() > 0) model_pop();
      else begin
        m_we   = 0;
        m_done = 1;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit w, input bit c,
                     input int a, input int b, input int cc, input int d);
    reset       = r;
    wr          = w;
    clearScreen = c;
    x0          = N'(a);
    y0          = N'(b);
    x1          = N'(cc);
    y1          = N'(d);
    model_step(r, w, c, a, b, cc, d);
    @(posedge clock);
    #1;
    cyc_n++;
    if (pix_we) n_writes++;
    check("pix_we", 32'(pix_we), 32'(m_we));
    check("done", 32'(done), 32'(m_done));
    check("ready", 32'(ready), 32'(!m_we && !m_pend));
    check("pix_x", 32'(pix_x), 32'(m_x));
    check("pix_y", 32'(pix_y), 32'(m_y));
    check("pix_color", 32'(pix_color), 32'(m_c));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic int rc();
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(0, (1 << N) - 1));
    return int'($urandom_range(0, 11));
  endfunction

  initial begin
    reset = 1'b1; wr = 1'b0; clearScreen = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;

    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(2);

    n_writes = 0; cyc(0, 1, 0, 1, 1, 2, 2); idle(6);
    check("cnt_basic", 32'(n_writes), 32'd4);
    n_writes = 0; cyc(0, 1, 0, 2, 2, 1, 1); idle(6);
    check("cnt_swapped", 32'(n_writes), 32'd4);
    n_writes = 0; cyc(0, 1, 0, 6, 3, 10, 9); idle(4);
    check("cnt_clamped", 32'(n_writes), 32'd2);
    n_writes = 0; cyc(0, 1, 0, 9, 0, 12, 1); idle(3);
    check("cnt_offscreen", 32'(n_writes), 32'd0);
    n_writes = 0; cyc(0, 1, 0, 5, 2, 5, 2); idle(3);
    check("cnt_single", 32'(n_writes), 32'd1);
    n_writes = 0; cyc(0, 1, 1, 1, 1, 2, 2); idle(36);
    check("cnt_clear_wins", 32'(n_writes), 32'd32);

    // Clear and a stray wr land while a 4-pixel fill is in progress.
    n_writes = 0;
    cyc(0, 1, 0, 1, 1, 2, 2);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 7, 3);
    idle(40);
    check("cnt_fill_then_clear", 32'(n_writes), 32'd36);

    // Reset while the second pixel of a fill is on the bus.
    cyc(0, 1, 0, 0, 0, 3, 0);
    idle(1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    n_writes = 0;
    cyc(0, 0, 0, 0, 0, 0, 0);
    idle(4);
    check("cnt_after_reset", 32'(n_writes), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 39) == 0), rc(), rc(), rc(), rc());
    end
    idle(40);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
